// File: rtl/seq_divider_8by4.sv
`default_nettype none
// ============================================================================
// Module  : seq_divider_8by4
// Brief   : Signed 8-bit / 4-bit restoring divider, one quotient bit per clock.
// Revision: 1.0 - initial release
// ============================================================================
module seq_divider_8by4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       dz,
  output logic       ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic [4:0] r_q, r_d;
  logic [7:0] q_q, q_d;
  logic [3:0] d_q, d_d;
  logic       sgn_a_q, sgn_a_d;
  logic       sgn_b_q, sgn_b_d;
  logic       dz_pend_q, dz_pend_d;
  logic       ovf_pend_q, ovf_pend_d;
  logic [7:0] quot_q, quot_d;
  logic [3:0] rem_q, rem_d;
  logic       dz_q, dz_d;
  logic       ovf_q, ovf_d;

  logic       w_accept;
  logic [4:0] w_r_sh;
  logic [7:0] w_q_sh;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    r_d        = r_q;
    q_d        = q_q;
    d_d        = d_q;
    sgn_a_d    = sgn_a_q;
    sgn_b_d    = sgn_b_q;
    dz_pend_d  = dz_pend_q;
    ovf_pend_d = ovf_pend_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dz_d       = dz_q;
    ovf_d      = ovf_q;

    w_accept = start && ((state_q == IDLE) || (state_q == DONE));
    w_r_sh   = {r_q[3:0], q_q[7]};
    w_q_sh   = {q_q[6:0], 1'b0};

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (w_accept) begin
          // Magnitudes fit unsigned: |-128| = 8'h80, |-8| = 4'h8
          sgn_a_d    = dividend[7];
          sgn_b_d    = divisor[3];
          q_d        = dividend[7] ? (~dividend + 8'd1) : dividend;
          d_d        = divisor[3]  ? (~divisor + 4'd1)  : divisor;
          r_d        = 5'd0;
          cnt_d      = 3'd0;
          last_d     = 1'b0;
          dz_pend_d  = (divisor == 4'h0);
          ovf_pend_d = (dividend == 8'h80) && (divisor == 4'hF);
          state_d    = DIV;
        end
      end
      DIV: begin
        if (!last_q) begin
          if (w_r_sh >= {1'b0, d_q}) begin
            r_d = w_r_sh - {1'b0, d_q};
            q_d = {w_q_sh[7:1], 1'b1};
          end else begin
            r_d = w_r_sh;
            q_d = w_q_sh;
          end
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            last_d = 1'b1;
          end
        end else begin
          // Sign correction; outputs only ever change on the edge into DONE
          if (dz_pend_q) begin
            quot_d = 8'hFF;
            rem_d  = 4'h0;
            dz_d   = 1'b1;
            ovf_d  = 1'b0;
          end else begin
            quot_d = (sgn_a_q ^ sgn_b_q) ? (~q_q + 8'd1) : q_q;
            rem_d  = sgn_a_q ? (~r_q[3:0] + 4'd1) : r_q[3:0];
            dz_d   = 1'b0;
            ovf_d  = ovf_pend_q;
          end
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      last_q     <= 1'b0;
      r_q        <= 5'd0;
      q_q        <= 8'd0;
      d_q        <= 4'd0;
      sgn_a_q    <= 1'b0;
      sgn_b_q    <= 1'b0;
      dz_pend_q  <= 1'b0;
      ovf_pend_q <= 1'b0;
      quot_q     <= 8'd0;
      rem_q      <= 4'd0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      r_q        <= r_d;
      q_q        <= q_d;
      d_q        <= d_d;
      sgn_a_q    <= sgn_a_d;
      sgn_b_q    <= sgn_b_d;
      dz_pend_q  <= dz_pend_d;
      ovf_pend_q <= ovf_pend_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dz_q       <= dz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy      = (state_q == DIV);
  assign done      = (state_q == DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dz        = dz_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire
